// File: rtl/vga_timer_overlay.sv
// Bus-programmable hh:mm:ss-style timer whose digits are drawn as glyphs over a VGA frame-buffer stream.
// Latency: ADDRH/ADDRV to PIXEL_OUT is 2 cycles; bus reads return data from the cycle after the address match; no backpressure.
module vga_timer_overlay #(
    parameter logic [7:0] BASE_ADDR  = 8'hB4,
    parameter int         NUM_DIGITS = 4,
    parameter int         DIGIT_W    = 31,
    parameter int         DIGIT_H    = 44,
    parameter int         START_X    = 238,
    parameter int         START_Y    = 218,
    parameter int         PRESCALE   = 100000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  BUS_ADDR,
    inout  wire  [7:0]  BUS_DATA,
    input  logic        BUS_WE,
    input  logic [9:0]  ADDRH,
    input  logic [9:0]  ADDRV,
    input  logic        FB_PIXEL,
    output logic [15:0] GLYPH_ADDR,
    input  logic        GLYPH_BIT,
    output logic        PIXEL_OUT,
    output logic        DONE
);

    localparam int NPAIR = NUM_DIGITS / 2;
    localparam int NCELL = NUM_DIGITS + NPAIR - 1;
    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    function automatic logic [3:0] dig_max(input int d);
        return (d % 2 == 1) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [3:0] clamp_dig(input logic [3:0] v, input logic [3:0] vmax);
        return (v > vmax) ? vmax : v;
    endfunction

    // ctrl_q: bit0 run, bit1 down, bit2 bus-tick source, bit3 overlay enable
    logic [3:0]    ctrl_q;
    logic          done_q;
    logic          roll_q;
    logic [3:0]    dig_q [NUM_DIGITS];
    logic [PW-1:0] presc_q;

    // ---------------- bus decode ----------------
    logic [7:0]       bus_off;
    logic             bus_hit;
    logic             rd_hit;
    logic             wr_ctrl;
    logic             wr_tick;
    logic             wr_clr;
    logic [NPAIR-1:0] wr_load;
    logic [7:0]       rd_dat;
    logic [7:0]       bus_q;
    logic             bus_oe_q;
    logic             rd_stat_q;

    assign bus_off = BUS_ADDR - BASE_ADDR;
    assign bus_hit = (bus_off < 8'd8);
    assign rd_hit  = bus_hit & ~BUS_WE;
    assign wr_ctrl = BUS_WE & (bus_off == 8'd0);
    assign wr_tick = BUS_WE & (bus_off == 8'd1);
    assign wr_clr  = BUS_WE & (bus_off == 8'd2);

    always_comb begin
        wr_load = '0;
        for (int k = 0; k < NPAIR; k++) begin
            wr_load[k] = BUS_WE & (bus_off == 8'(4 + k));
        end
    end

    always_comb begin
        rd_dat = 8'h00;
        if (bus_off == 8'd0) begin
            rd_dat = {4'b0000, ctrl_q};
        end else if (bus_off == 8'd3) begin
            rd_dat = {6'b000000, roll_q, done_q};
        end
        for (int k = 0; k < NPAIR; k++) begin
            if (bus_off == 8'(4 + k)) begin
                rd_dat = {dig_q[2*k+1], dig_q[2*k]};
            end
        end
    end

    // Enable is gated by the live address so the driver lets go as soon as the master moves away.
    assign BUS_DATA = (bus_oe_q & rd_hit) ? bus_q : 8'bz;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus_oe_q  <= 1'b0;
            bus_q     <= 8'h00;
            rd_stat_q <= 1'b0;
        end else begin
            bus_oe_q  <= rd_hit;
            bus_q     <= rd_dat;
            rd_stat_q <= rd_hit & (bus_off == 8'd3);
        end
    end

    // ---------------- tick generation ----------------
    logic presc_wrap;
    logic tick;

    assign presc_wrap = (presc_q == PW'(PRESCALE - 1));
    assign tick       = ctrl_q[0] & (ctrl_q[2] ? wr_tick : presc_wrap);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_q <= '0;
        end else if (ctrl_q[0] & ~ctrl_q[2]) begin
            presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
        end
    end

    // ---------------- ripple counter ----------------
    logic [3:0] tick_dig [NUM_DIGITS];
    logic       tick_cy;
    logic       tick_zero;

    always_comb begin
        tick_dig = dig_q;
        tick_cy  = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (tick_cy) begin
                if (!ctrl_q[1]) begin
                    if (dig_q[d] == dig_max(d)) begin
                        tick_dig[d] = 4'd0;
                    end else begin
                        tick_dig[d] = dig_q[d] + 4'd1;
                        tick_cy     = 1'b0;
                    end
                end else begin
                    if (dig_q[d] == 4'd0) begin
                        tick_dig[d] = dig_max(d);
                    end else begin
                        tick_dig[d] = dig_q[d] - 4'd1;
                        tick_cy     = 1'b0;
                    end
                end
            end
        end
        // A borrow out of the top digit means we were already at zero: hold there.
        if (ctrl_q[1] && tick_cy) begin
            tick_dig = dig_q;
        end
        tick_zero = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (tick_dig[d] != 4'd0) begin
                tick_zero = 1'b0;
            end
        end
    end

    // Later assignments win: clear over load over tick.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_q <= 4'd0;
            done_q <= 1'b0;
            roll_q <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                dig_q[d] <= 4'd0;
            end
        end else begin
            if (rd_stat_q) begin
                roll_q <= 1'b0;
            end
            if (tick) begin
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    dig_q[d] <= tick_dig[d];
                end
                if (ctrl_q[1] && tick_zero) begin
                    done_q    <= 1'b1;
                    ctrl_q[0] <= 1'b0;
                end
                if (!ctrl_q[1] && tick_cy) begin
                    roll_q <= 1'b1;
                end
            end
            if (wr_ctrl) begin
                ctrl_q <= BUS_DATA[3:0];
                if (BUS_DATA[0]) begin
                    done_q <= 1'b0;
                end
            end
            for (int k = 0; k < NPAIR; k++) begin
                if (wr_load[k]) begin
                    dig_q[2*k+1] <= clamp_dig(BUS_DATA[7:4], dig_max(2*k+1));
                    dig_q[2*k]   <= clamp_dig(BUS_DATA[3:0], dig_max(2*k));
                    done_q       <= 1'b0;
                end
            end
            if (wr_clr) begin
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    dig_q[d] <= 4'd0;
                end
                done_q <= 1'b0;
                roll_q <= 1'b0;
            end
        end
    end

    assign DONE = done_q;

    // ---------------- overlay pipeline ----------------
    logic [10:0] rel_x;
    logic [10:0] rel_y;
    logic        in_x;
    logic        in_y;
    logic        s1_in;
    logic [3:0]  s1_g;
    logic [9:0]  s1_x;
    logic [9:0]  s1_y;
    logic        in_q;
    logic [3:0]  g_q;
    logic [9:0]  x_q;
    logic [9:0]  y_q;
    logic        fb_d1;

    assign rel_x = {1'b0, ADDRH} - 11'(START_X);
    assign rel_y = {1'b0, ADDRV} - 11'(START_Y);
    assign in_x  = ({1'b0, ADDRH} >= 11'(START_X)) && (rel_x < 11'(NCELL * DIGIT_W));
    assign in_y  = ({1'b0, ADDRV} >= 11'(START_Y)) && (rel_y < 11'(DIGIT_H));

    // Cells repeat as [hi digit][lo digit][colon], MSB pair first; the trailing colon is never reached.
    always_comb begin
        s1_in = 1'b0;
        s1_g  = 4'd0;
        s1_x  = 10'd0;
        s1_y  = 10'd0;
        if (in_x && in_y) begin
            s1_in = 1'b1;
            s1_y  = 10'(rel_y);
            for (int c = 0; c < NCELL; c++) begin
                if (rel_x >= 11'(c * DIGIT_W) && rel_x < 11'((c + 1) * DIGIT_W)) begin
                    s1_x = 10'(rel_x - 11'(c * DIGIT_W));
                    if (c % 3 == 2) begin
                        s1_g = 4'd10;
                    end else begin
                        s1_g = dig_q[NUM_DIGITS - 1 - 2 * (c / 3) - (c % 3)];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_q      <= 1'b0;
            g_q       <= 4'd0;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            fb_d1     <= 1'b0;
            PIXEL_OUT <= 1'b0;
        end else begin
            in_q      <= s1_in;
            g_q       <= s1_g;
            x_q       <= s1_x;
            y_q       <= s1_y;
            fb_d1     <= FB_PIXEL;
            PIXEL_OUT <= (ctrl_q[3] & in_q) ? GLYPH_BIT : fb_d1;
        end
    end

    // Cell coordinates are zeroed outside the region, so the address rests at 0 there.
    assign GLYPH_ADDR = 16'(g_q) * 16'(DIGIT_W * DIGIT_H) + 16'(y_q) * 16'(DIGIT_W) + 16'(x_q);

endmodule

// File: tb/tb_vga_timer_overlay.sv
// Directed bench for vga_timer_overlay: bus register map, counting, status flags and overlay pipeline.
module tb_vga_timer_overlay;

    localparam logic [7:0] BASE = 8'hB4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  BUS_ADDR;
    wire  [7:0]  BUS_DATA;
    logic        BUS_WE;
    logic [9:0]  ADDRH;
    logic [9:0]  ADDRV;
    logic        FB_PIXEL;
    logic [15:0] GLYPH_ADDR;
    logic        GLYPH_BIT;
    logic        PIXEL_OUT;
    logic        DONE;

    logic        tb_oe;
    logic [7:0]  tb_dat;
    int          n_vec = 0;
    int          n_err = 0;

    assign BUS_DATA  = tb_oe ? tb_dat : 8'bz;
    // Glyph memory stand-in: pixel bit is address bit 3.
    assign GLYPH_BIT = GLYPH_ADDR[3];

    always #5 CLK = ~CLK;

    vga_timer_overlay #(.PRESCALE(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_DATA   (BUS_DATA),
        .BUS_WE     (BUS_WE),
        .ADDRH      (ADDRH),
        .ADDRV      (ADDRV),
        .FB_PIXEL   (FB_PIXEL),
        .GLYPH_ADDR (GLYPH_ADDR),
        .GLYPH_BIT  (GLYPH_BIT),
        .PIXEL_OUT  (PIXEL_OUT),
        .DONE       (DONE)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [7:0] off, input logic [7:0] d);
        @(negedge CLK);
        BUS_ADDR = BASE + off;
        tb_dat   = d;
        tb_oe    = 1'b1;
        BUS_WE   = 1'b1;
        @(negedge CLK);
        BUS_WE   = 1'b0;
        tb_oe    = 1'b0;
        BUS_ADDR = 8'h00;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] off, input logic [7:0] exp);
        logic [7:0] d;
        @(negedge CLK);
        BUS_ADDR = BASE + off;
        BUS_WE   = 1'b0;
        @(negedge CLK);
        d        = BUS_DATA;
        BUS_ADDR = 8'h00;
        chk(tag, d, exp);
    endtask

    task automatic pix_chk(input string tag, input logic [9:0] h, input logic [9:0] v,
                           input logic fb, input logic [15:0] exp_addr, input logic exp_pix);
        @(negedge CLK);
        ADDRH    = h;
        ADDRV    = v;
        FB_PIXEL = fb;
        @(negedge CLK);
        chk({tag, "_addr"}, GLYPH_ADDR, exp_addr);
        @(negedge CLK);
        chk({tag, "_pix"}, PIXEL_OUT, exp_pix);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [6:0] pat;
        RESET    = 1'b1;
        BUS_ADDR = 8'h00;
        BUS_WE   = 1'b0;
        tb_oe    = 1'b0;
        tb_dat   = 8'h00;
        ADDRH    = 10'd0;
        ADDRV    = 10'd0;
        FB_PIXEL = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        chk("rst_done", DONE, 1'b0);
        chk("rst_pix", PIXEL_OUT, 1'b0);
        chk("rst_gaddr", GLYPH_ADDR, 16'd0);
        rd_chk("rst_ctrl", 8'd0, 8'h00);
        rd_chk("rst_stat", 8'd3, 8'h00);
        rd_chk("rst_pair0", 8'd4, 8'h00);

        // Prescaler source: 40 running cycles at PRESCALE=4 give 10 ticks.
        bus_wr(8'd0, 8'h01);
        repeat (38) @(negedge CLK);
        bus_wr(8'd0, 8'h00);
        rd_chk("presc_pair0", 8'd4, 8'h10);
        rd_chk("presc_pair1", 8'd5, 8'h00);
        repeat (10) @(negedge CLK);
        rd_chk("presc_hold", 8'd4, 8'h10);

        // Three bus ticks from zero.
        bus_wr(8'd2, 8'h00);
        bus_wr(8'd0, 8'h05);
        repeat (3) bus_wr(8'd1, 8'h00);
        rd_chk("bt3_pair0", 8'd4, 8'h03);
        rd_chk("bt3_pair1", 8'd5, 8'h00);
        rd_chk("ctrl_rd", 8'd0, 8'h05);

        // Rollover 59:59 -> 00:00 and sticky ROLL cleared by reading it.
        bus_wr(8'd4, 8'h59);
        bus_wr(8'd5, 8'h59);
        bus_wr(8'd1, 8'h00);
        rd_chk("roll_pair0", 8'd4, 8'h00);
        rd_chk("roll_pair1", 8'd5, 8'h00);
        rd_chk("roll_stat1", 8'd3, 8'h02);
        rd_chk("roll_stat2", 8'd3, 8'h00);

        // Carry across the pair boundary, then borrow back.
        bus_wr(8'd5, 8'h09);
        bus_wr(8'd4, 8'h59);
        bus_wr(8'd1, 8'h00);
        rd_chk("carry_pair1", 8'd5, 8'h10);
        rd_chk("carry_pair0", 8'd4, 8'h00);
        bus_wr(8'd0, 8'h07);
        bus_wr(8'd1, 8'h00);
        rd_chk("borrow_pair1", 8'd5, 8'h09);
        rd_chk("borrow_pair0", 8'd4, 8'h59);

        // Countdown to zero sets DONE and stops; further ticks are ignored.
        bus_wr(8'd5, 8'h00);
        bus_wr(8'd4, 8'h02);
        bus_wr(8'd1, 8'h00);
        rd_chk("down_pair0", 8'd4, 8'h01);
        chk("down_notdone", DONE, 1'b0);
        bus_wr(8'd1, 8'h00);
        rd_chk("down0_pair0", 8'd4, 8'h00);
        chk("down0_done", DONE, 1'b1);
        rd_chk("down0_stat", 8'd3, 8'h01);
        rd_chk("down0_ctrl", 8'd0, 8'h06);
        bus_wr(8'd1, 8'h00);
        rd_chk("down0_hold0", 8'd4, 8'h00);
        rd_chk("down0_hold1", 8'd5, 8'h00);

        // Out-of-range loads clamp; a load clears DONE.
        bus_wr(8'd4, 8'hFF);
        bus_wr(8'd5, 8'h7A);
        rd_chk("clamp_pair0", 8'd4, 8'h59);
        rd_chk("clamp_pair1", 8'd5, 8'h59);
        chk("load_clr_done", DONE, 1'b0);

        // Clear lands on the same edge as a prescaler tick.
        bus_wr(8'd5, 8'h12);
        bus_wr(8'd4, 8'h34);
        bus_wr(8'd0, 8'h01);
        repeat (2) @(negedge CLK);
        bus_wr(8'd2, 8'h00);
        bus_wr(8'd0, 8'h00);
        rd_chk("clrtick_pair0", 8'd4, 8'h00);
        rd_chk("clrtick_pair1", 8'd5, 8'h00);
        rd_chk("clrtick_stat", 8'd3, 8'h00);

        // Overlay pipeline with digits 12:34.
        bus_wr(8'd5, 8'h12);
        bus_wr(8'd4, 8'h34);
        bus_wr(8'd0, 8'h08);
        pix_chk("colon", 10'd300, 10'd218, 1'b0, 16'd13640, 1'b1);
        pix_chk("dig1", 10'd336, 10'd220, 1'b0, 16'd4159, 1'b1);
        pix_chk("corner", 10'd392, 10'd261, 1'b1, 16'd6819, 1'b0);
        pix_chk("right_out", 10'd393, 10'd261, 1'b1, 16'd0, 1'b1);
        pix_chk("below_out", 10'd300, 10'd262, 1'b0, 16'd0, 1'b0);
        bus_wr(8'd0, 8'h00);
        pix_chk("ovl_off", 10'd300, 10'd218, 1'b0, 16'd13640, 1'b0);

        // Frame-buffer passthrough is delayed exactly two cycles.
        bus_wr(8'd0, 8'h08);
        ADDRH = 10'd0;
        ADDRV = 10'd0;
        pat   = 7'b1011001;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            if (i >= 2) chk("fb_delay", PIXEL_OUT, pat[i-2]);
            FB_PIXEL = pat[i];
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
